rank_pipe_reader: RTL

RANK_PIPE_READER -- requirements
Module: rank_pipe_reader

---
 rtl/rank_pipe_reader.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/rank_pipe_reader.sv
// Drains a fall-through rank pipe into a PIFO through a 2-entry in-order skid buffer,
// with a flush sequence that discards buffered and arriving entries and counts them.
module rank_pipe_reader #(
    parameter int RANK_WIDTH  = 16,
    parameter int META_WIDTH  = 16,
    parameter int COUNT_WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   rp_valid,
    input  logic [RANK_WIDTH-1:0]  rp_rank,
    input  logic [META_WIDTH-1:0]  rp_meta,
    output logic                   rp_remove,
    input  logic                   pifo_busy,
    output logic                   pifo_insert,
    output logic [RANK_WIDTH-1:0]  pifo_rank,
    output logic [META_WIDTH-1:0]  pifo_meta,
    input  logic                   flush,
    output logic                   flush_done,
    output logic [1:0]             buf_level,
    output logic [COUNT_WIDTH-1:0] insert_count,
    output logic [COUNT_WIDTH-1:0] drop_count
);

    typedef enum logic [1:0] {
        S_RUN   = 2'd0,
        S_FLUSH = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t                 r_state;
    state_t                 w_state_next;

    // Slot 0 is always the head; slot 1 holds the second entry when level is 2.
    logic [RANK_WIDTH-1:0]  r_rank [2];
    logic [META_WIDTH-1:0]  r_meta [2];
    logic [1:0]             r_level;
    logic [COUNT_WIDTH-1:0] r_insert_count;
    logic [COUNT_WIDTH-1:0] r_drop_count;

    logic                   w_remove;
    logic                   w_insert;
    logic                   w_push;
    logic                   w_clear;
    logic                   w_flush_done;
    logic [1:0]             w_drop_inc;
    logic [COUNT_WIDTH:0]   w_drop_sum;

    // NOTE: every output of this block gets a default first, so no path leaves a
    // variable unassigned and no latch is inferred.
    always_comb begin
        w_state_next = r_state;
        w_remove     = 1'b0;
        w_insert     = 1'b0;
        w_clear      = 1'b0;
        w_flush_done = 1'b0;
        w_drop_inc   = 2'd0;

        case (r_state)
            S_RUN: begin
                if (flush) begin
                    w_clear      = 1'b1;
                    w_drop_inc   = r_level;
                    w_state_next = S_FLUSH;
                end else begin
                    w_remove = rp_valid && (r_level != 2'd2);
                    w_insert = (r_level != 2'd0) && !pifo_busy;
                end
            end
            S_FLUSH: begin
                w_remove   = rp_valid;
                w_drop_inc = {1'b0, rp_valid};
                if (!flush && !rp_valid) begin
                    w_state_next = S_DONE;
                end
            end
            S_DONE: begin
                w_flush_done = 1'b1;
                w_state_next = S_RUN;
            end
            default: begin
                w_state_next = S_RUN;
            end
        endcase

        // Strobes must stay quiet for the whole reset cycle, not only after the edge.
        if (rst) begin
            w_remove     = 1'b0;
            w_insert     = 1'b0;
            w_flush_done = 1'b0;
            w_drop_inc   = 2'd0;
        end
    end

    // Entries removed during FLUSH are discarded, so only RUN removals are pushed.
    assign w_push     = w_remove && (r_state == S_RUN);
    assign w_drop_sum = {1'b0, r_drop_count} + (COUNT_WIDTH + 1)'(w_drop_inc);

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // the pre-edge value of every other register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= S_RUN;
            r_level        <= 2'd0;
            r_insert_count <= '0;
            r_drop_count   <= '0;
        end else begin
            r_state <= w_state_next;

            if (w_clear) begin
                r_level <= 2'd0;
            end else if (w_push && !w_insert) begin
                r_level <= r_level + 2'd1;
            end else if (w_insert && !w_push) begin
                r_level <= r_level - 2'd1;
            end

            if (w_insert && (r_insert_count != '1)) begin
                r_insert_count <= r_insert_count + COUNT_WIDTH'(1);
            end

            if (w_drop_sum[COUNT_WIDTH]) begin
                r_drop_count <= '1;
            end else begin
                r_drop_count <= w_drop_sum[COUNT_WIDTH-1:0];
            end
        end
    end

    // NOTE: the payload storage has no reset; r_level alone decides which slots are
    // meaningful, and empty-buffer outputs are forced to zero below.
    always_ff @(posedge clk) begin
        if (w_insert) begin
            r_rank[0] <= w_push ? rp_rank : r_rank[1];
            r_meta[0] <= w_push ? rp_meta : r_meta[1];
        end else if (w_push) begin
            if (r_level == 2'd0) begin
                r_rank[0] <= rp_rank;
                r_meta[0] <= rp_meta;
            end else begin
                r_rank[1] <= rp_rank;
                r_meta[1] <= rp_meta;
            end
        end
    end

    assign rp_remove    = w_remove;
    assign pifo_insert  = w_insert;
    assign pifo_rank    = (r_level != 2'd0) ? r_rank[0] : '0;
    assign pifo_meta    = (r_level != 2'd0) ? r_meta[0] : '0;
    assign flush_done   = w_flush_done;
    assign buf_level    = r_level;
    assign insert_count = r_insert_count;
    assign drop_count   = r_drop_count;

endmodule
